// File: rtl/param_rom_arbiter.sv
// Round-robin arbiter granting burst reads of a shared, fixed-latency parameter ROM.
// Read data returns through a tag pipeline that tracks the owner and the last word of each burst.
module param_rom_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 10,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic                          rom_read,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e                       state_q;
    logic [OW-1:0]                rr_ptr_q;
    logic [OW-1:0]                owner_q;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [LEN_WIDTH-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0]        rom_addr_q;
    logic                         rom_read_q;
    logic [NUM_REQ-1:0]           grant_q;
    logic                         zero_done_q;
    logic [ROM_LATENCY-1:0]       tag_vld_q;
    logic [ROM_LATENCY-1:0]       tag_last_q;
    logic [ROM_LATENCY-1:0][OW-1:0] tag_own_q;

    logic [OW-1:0]                pick;
    logic [OW-1:0]                cand;
    logic                         pick_vld;
    logic [LEN_WIDTH-1:0]         sel_len;
    logic [ADDR_WIDTH-1:0]        sel_addr;
    logic                         last_rd;
    logic                         tag_done;
    logic                         done_any;
    logic [OW-1:0]                owner_nxt;

    // First asserted requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick     = rr_ptr_q;
        cand     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = OW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign sel_len   = req_len[32'(pick)*LEN_WIDTH +: LEN_WIDTH];
    assign sel_addr  = req_addr[32'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
    assign last_rd   = (state_q == StBurst) && (cnt_q == len_q - LEN_WIDTH'(1));
    assign tag_done  = tag_vld_q[ROM_LATENCY-1] & tag_last_q[ROM_LATENCY-1];
    assign done_any  = zero_done_q | tag_done;
    assign owner_nxt = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            rom_read_q  <= 1'b0;
            grant_q     <= '0;
            zero_done_q <= 1'b0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
            tag_own_q   <= '0;
        end else begin
            grant_q      <= '0;
            zero_done_q  <= 1'b0;
            tag_vld_q[0] <= rom_read_q;
            tag_last_q[0] <= last_rd;
            tag_own_q[0] <= owner_q;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
                tag_own_q[i]  <= tag_own_q[i-1];
            end
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        owner_q    <= pick;
                        len_q      <= sel_len;
                        cnt_q      <= '0;
                        rom_addr_q <= sel_addr;
                        grant_q    <= NUM_REQ'(1) << pick;
                        // A zero-length burst skips the ROM and completes with its grant.
                        if (sel_len == '0) begin
                            zero_done_q <= 1'b1;
                            state_q     <= StDrain;
                        end else begin
                            rom_read_q <= 1'b1;
                            state_q    <= StBurst;
                        end
                    end
                end
                StBurst: begin
                    if (last_rd) begin
                        rom_read_q <= 1'b0;
                        state_q    <= StDrain;
                    end else begin
                        cnt_q      <= cnt_q + LEN_WIDTH'(1);
                        rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
                    end
                end
                StDrain: begin
                    if (done_any) begin
                        rr_ptr_q <= owner_nxt;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rd_valid = '0;
        done     = '0;
        if (tag_vld_q[ROM_LATENCY-1]) rd_valid[tag_own_q[ROM_LATENCY-1]] = 1'b1;
        if (tag_done) done[tag_own_q[ROM_LATENCY-1]] = 1'b1;
        if (zero_done_q) done[owner_q] = 1'b1;
    end

    assign rd_data  = tag_vld_q[ROM_LATENCY-1] ? rom_data : '0;
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);
    assign rom_read = rom_read_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_param_rom_arbiter.sv
// Directed bench for param_rom_arbiter (NUM_REQ=4, ROM_LATENCY=1) with a behavioural ROM.
module tb_param_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_addr;
    logic [39:0] req_len;
    logic [3:0]  grant, rd_valid, done;
    logic [31:0] rd_data, rom_data;
    logic        busy, rom_read;
    logic [15:0] rom_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    param_rom_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(10), .ROM_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
        .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // One-cycle-latency ROM.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [9:0] l);
        req_addr[i*16 +: 16] = a;
        req_len[i*10 +: 10]  = l;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_addr = '0; req_len = '0;
        cyc(); cyc();
        n_cmp++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (rd_valid !== 4'b0 || done !== 4'b0) begin n_fail++; $display("FAIL reset_rv_done: got %b/%b want 0000/0000", rd_valid, done); end
        n_cmp++; if (busy !== 1'b0 || rom_read !== 1'b0) begin n_fail++; $display("FAIL reset_busy_read: got %b/%b want 0/0", busy, rom_read); end
        n_cmp++; if (rom_addr !== 16'h0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", rom_addr, rd_data); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        logic [3:0]  eg[5] = '{4'b0010, 4'b0, 4'b0, 4'b0, 4'b0};
        logic        er[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] ea[5] = '{16'h10, 16'h11, 16'h12, 16'h12, 16'h12};
        logic [3:0]  ev[5] = '{4'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0};
        logic [3:0]  ed[5] = '{4'b0, 4'b0, 4'b0, 4'b0010, 4'b0};
        logic        eb[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] dd[5];
        dd = '{32'h0, rom_word(16'h10), rom_word(16'h11), rom_word(16'h12), 32'h0};
        set_req(1, 16'h0010, 10'd3);
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 0) req = 4'b0;
            n_cmp++; if (grant !== eg[c]) begin n_fail++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, eg[c]); end
            n_cmp++; if (rom_read !== er[c] || rom_addr !== ea[c]) begin n_fail++; $display("FAIL single_rom c%0d: got %b/%h want %b/%h", c, rom_read, rom_addr, er[c], ea[c]); end
            n_cmp++; if (rd_valid !== ev[c] || rd_data !== dd[c]) begin n_fail++; $display("FAIL single_rd c%0d: got %b/%h want %b/%h", c, rd_valid, rd_data, ev[c], dd[c]); end
            n_cmp++; if (done !== ed[c] || busy !== eb[c]) begin n_fail++; $display("FAIL single_done c%0d: got %b/%b want %b/%b", c, done, busy, ed[c], eb[c]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] eg[8] = '{4'b0001, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0, 4'b0, 4'b0};
        logic [3:0] ed[8] = '{4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0};
        logic       eb[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        set_req(0, 16'h0100, 10'd2);
        set_req(2, 16'h0200, 10'd2);
        req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            cyc();
            n_cmp++; if (grant !== eg[c]) begin n_fail++; $display("FAIL simul_grant c%0d: got %b want %b", c, grant, eg[c]); end
            n_cmp++; if (done !== ed[c] || busy !== eb[c]) begin n_fail++; $display("FAIL simul_done c%0d: got %b/%b want %b/%b", c, done, busy, ed[c], eb[c]); end
            if (done[0]) req[0] = 1'b0;
            if (done[2]) req[2] = 1'b0;
        end
        n_cmp++; if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL simul_rr_ptr: got %0d want 3", dut.rr_ptr_q); end
    endtask

    task automatic test_fairness();
        int order[$];
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        for (int i = 0; i < 4; i++) set_req(i, 16'(16'h1000 * i), 10'd1);
        req = 4'b1111;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            cyc();
            for (int i = 0; i < 4; i++) if (grant[i]) order.push_back(i);
        end
        req = 4'b0;
        n_cmp++; if (order.size() != 6) begin n_fail++; $display("FAIL fair_count: got %0d want 6", order.size()); end
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            n_cmp++; if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL fair_order %0d: got %0d want %0d", i, order[i], exp_order[i]); end
        end
        cyc(); cyc(); cyc();
    endtask

    task automatic test_zero_len();
        set_req(3, 16'h0300, 10'd0);
        req = 4'b1000;
        cyc();
        req = 4'b0;
        n_cmp++; if (grant !== 4'b1000 || done !== 4'b1000) begin n_fail++; $display("FAIL zero_grant_done: got %b/%b want 1000/1000", grant, done); end
        n_cmp++; if (rom_read !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_read_busy: got %b/%b want 0/1", rom_read, busy); end
        cyc();
        n_cmp++; if (grant !== 4'b0 || done !== 4'b0 || rom_read !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after: got %b/%b/%b/%b want 0000/0000/0/0", grant, done, rom_read, busy); end
        n_cmp++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL zero_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    endtask

    task automatic test_wrap();
        logic [15:0] ea[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [31:0] dd[3];
        dd = '{rom_word(16'hFFFE), rom_word(16'hFFFF), rom_word(16'h0000)};
        set_req(1, 16'hFFFE, 10'd3);
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c == 0) req = 4'b0;
            if (c < 3) begin
                n_cmp++; if (rom_read !== 1'b1 || rom_addr !== ea[c]) begin n_fail++; $display("FAIL wrap_addr c%0d: got %b/%h want 1/%h", c, rom_read, rom_addr, ea[c]); end
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (rd_valid !== 4'b0010 || rd_data !== dd[c-1]) begin n_fail++; $display("FAIL wrap_data c%0d: got %b/%h want 0010/%h", c, rd_valid, rd_data, dd[c-1]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_req(2, 16'h0040, 10'd5);
        req = 4'b0100;
        cyc();
        req = 4'b0;
        cyc(); cyc();
        n_cmp++; if (rom_addr !== 16'h0042 || rd_valid !== 4'b0100) begin n_fail++; $display("FAIL mid_pre: got %h/%b want 0042/0100", rom_addr, rd_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0 || rd_valid !== 4'b0 || done !== 4'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b/%b/%b want 0", grant, rd_valid, done); end
        n_cmp++; if (busy !== 1'b0 || rom_read !== 1'b0 || rd_data !== 32'h0 || rom_addr !== 16'h0) begin n_fail++; $display("FAIL mid_rst_outs: got %b/%b/%h/%h want 0", busy, rom_read, rd_data, rom_addr); end
        cyc(); cyc();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            n_cmp++; if (rd_valid !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after c%0d: got %b/%b/%b want 0000/0000/0", c, rd_valid, done, busy); end
        end
        set_req(0, 16'h0500, 10'd1);
        set_req(3, 16'h0600, 10'd1);
        req = 4'b1001;
        cyc();
        req = 4'b0;
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_next_grant: got %b want 0001", grant); end
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/param_rom_arbiter.md
PARAM_ROM_ARBITER -- requirements
Module: param_rom_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4: number of layer requesters.
- ADDR_WIDTH, default 16: ROM word address width.
- DATA_WIDTH, default 32: ROM word width.
- LEN_WIDTH, default 10: burst length field width.
- ROM_LATENCY, default 1: cycles from rom_read to valid rom_data, range 1..4.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester burst request, level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester base address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  per-requester word count; slice i at [i*LEN_WIDTH +: LEN_WIDTH].
- grant  out  NUM_REQ  one-hot, one-cycle pulse on burst acceptance.
- rd_valid  out  NUM_REQ  one-hot; rd_data is valid for the flagged requester.
- rd_data  out  DATA_WIDTH  shared read data.
- done  out  NUM_REQ  one-hot, one-cycle pulse at burst completion.
- busy  out  1  high in any state other than IDLE.
- rom_read  out  1  ROM read strobe.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_data  in  DATA_WIDTH  ROM read data.

Function
REQ-003 The FSM SHALL have three states: IDLE, BURST and DRAIN.

REQ-004 In IDLE with req != 0 at a clock edge, the arbiter SHALL perform the following at that edge:
- select the first asserted requester at index rr_ptr, rr_ptr+1, ... modulo NUM_REQ;
- latch the owner, base address and length;
- clear the word counter;
- enter BURST.

REQ-005 grant[owner] SHALL be high for exactly the first BURST cycle.
- The requester's req, req_addr and req_len are sampled only at the acceptance edge.
- Changes after acceptance SHALL be ignored.

REQ-006 In BURST, rom_read SHALL be 1 and rom_addr SHALL be (base + cnt) mod 2^ADDR_WIDTH; cnt increments by 1 each cycle.

REQ-007 When cnt == len-1, the arbiter SHALL enter DRAIN on the next edge.
- Exactly len consecutive reads SHALL be issued, with no gaps.

REQ-008 In IDLE and DRAIN, rom_read SHALL be 0 and rom_addr SHALL hold its last value.

REQ-009 A read-tag pipeline of depth ROM_LATENCY SHALL carry (read, last, owner).
- rd_valid[owner] SHALL be 1 exactly ROM_LATENCY cycles after each rom_read cycle.
- rd_data SHALL equal rom_data in that same cycle.

REQ-010 done[owner] SHALL pulse in the same cycle as the rd_valid of the last word.

REQ-011 DRAIN SHALL return to IDLE on the edge ending the done cycle.
- On that edge, rr_ptr SHALL become (owner+1) mod NUM_REQ.

REQ-012 First-read latency SHALL be 1 cycle from the acceptance edge.

REQ-013 Back-to-back bursts SHALL have an inter-burst gap of at least 1 IDLE cycle.
- A requester SHALL deassert req on seeing its done pulse, or it is re-queued per round-robin order.

REQ-014 req_len == 0 SHALL be handled as follows:
- the requester is accepted;
- grant and done pulse together in one cycle;
- rom_read is never asserted;
- the FSM returns to IDLE next edge;
- rr_ptr advances as in REQ-011.

REQ-015 Requests arriving while busy SHALL wait and SHALL NOT affect the current burst.

REQ-016 Simultaneous requests SHALL be resolved purely by rr_ptr order.
- No requester SHALL wait more than NUM_REQ-1 bursts.

REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH, with no error flag.

REQ-018 At most one bit of each of grant, rd_valid and done SHALL be high in any cycle.

Reset
REQ-019 When rst is low, asynchronously and independently of clk, the block SHALL:
- enter IDLE;
- clear rr_ptr, cnt, owner, the tag pipeline and rom_addr;
- drive grant, rd_valid, done, busy, rom_read and rd_data to 0.

REQ-020 On reset mid-burst, in-flight reads SHALL be discarded.
- No rd_valid or done SHALL be produced for them after reset release.

REQ-021 The first request after rst rises SHALL be arbitrated starting from requester 0.

Verification (NUM_REQ=4, ROM_LATENCY=1)
REQ-022 A bench SHALL cover these directed scenarios:
- Single burst: req[1], addr 0x0010, len 3 -> grant[1] pulse; rom_addr 0x0010, 0x0011, 0x0012 on 3 consecutive cycles; rd_valid[1] on the 3 following cycles, each carrying that address's ROM word; done[1] with the third; busy low after.
- Simultaneous requests: req[0] and req[2] together after reset, len 2 each -> requester 0 fully served first, then requester 2; rr_ptr = 3 at the end.
- Fairness: req = 4'b1111 held continuously, len 1 -> grant order 0, 1, 2, 3, 0, 1, ...
- Zero length: req[3], len 0 -> grant[3] and done[3] in the same cycle; rom_read stays 0.
- Address wrap: base 0xFFFE, len 3 -> rom_addr 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-burst: rst low during word 2 of a len-5 burst -> all outputs 0 immediately; no rd_valid or done after release; next request is arbitrated starting from requester 0.
